// File: rtl/game2048_pkg.sv
// rtl/game2048_pkg.sv - shared direction encodings and move_cmd_gen state encoding
package game2048_pkg;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    MCG_IDLE         = 2'd0,
    MCG_DEBOUNCE     = 2'd1,
    MCG_ISSUE        = 2'd2,
    MCG_WAIT_RELEASE = 2'd3
  } mcg_state_t;

  // Button pattern bits are ordered {right, left, down, up}; up wins ties.
  function automatic logic [3:0] prio_dir(input logic [3:0] pat);
    if (pat[0])      return DIR_UP;
    else if (pat[1]) return DIR_DOWN;
    else if (pat[2]) return DIR_LEFT;
    else if (pat[3]) return DIR_RIGHT;
    else             return 4'b0000;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - 4-bit two-flop synchronizer for raw push-buttons
module btn_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] raw,
  output logic [3:0] sync
);

  logic [3:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 4'b0000;
      sync <= 4'b0000;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

endmodule

// File: rtl/move_cmd_gen.sv
// rtl/move_cmd_gen.sv - debounced push-button to one-shot move command generator
module move_cmd_gen
  import game2048_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic       cmd_valid,
  output logic [3:0] cmd_dir,
  input  logic       cmd_ready
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] btn_raw;
  logic [3:0] btn_s;

  mcg_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       pat, pat_d;
  logic [3:0]       dir, dir_d;

  assign btn_raw = {btnR, btnL, btnD, btnU};

  btn_sync u_btn_sync (
    .clk   (Clk),
    .reset (Reset),
    .raw   (btn_raw),
    .sync  (btn_s)
  );

  // Reset parks in WAIT_RELEASE so a button held across reset is never issued.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= MCG_WAIT_RELEASE;
      cnt   <= '0;
      pat   <= 4'b0000;
      dir   <= 4'b0000;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pat   <= pat_d;
      dir   <= dir_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pat_d   = pat;
    dir_d   = dir;
    case (state)
      MCG_IDLE: begin
        if (btn_s != 4'b0000) begin
          pat_d   = btn_s;
          cnt_d   = '0;
          state_d = MCG_DEBOUNCE;
        end
      end
      MCG_DEBOUNCE: begin
        if (btn_s == 4'b0000) begin
          cnt_d   = '0;
          state_d = MCG_IDLE;
        end else if (btn_s != pat) begin
          pat_d = btn_s;
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          dir_d   = prio_dir(pat);
          state_d = MCG_ISSUE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      MCG_ISSUE: begin
        // Buttons are ignored here: only the handshake can end the command.
        if (cmd_ready) begin
          cnt_d   = '0;
          dir_d   = 4'b0000;
          state_d = MCG_WAIT_RELEASE;
        end
      end
      MCG_WAIT_RELEASE: begin
        if (btn_s != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = MCG_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        dir_d   = 4'b0000;
        state_d = MCG_WAIT_RELEASE;
      end
    endcase
  end

  assign cmd_valid = (state == MCG_ISSUE);
  assign cmd_dir   = cmd_valid ? dir : 4'b0000;

endmodule

// File: tb/tb_move_cmd_gen.sv
// tb/tb_move_cmd_gen.sv - self-checking bench for move_cmd_gen with DEBOUNCE_CYCLES = 4
module tb_move_cmd_gen;

  localparam int D = 4;
  localparam logic [3:0] B_U = 4'b0001;
  localparam logic [3:0] B_D = 4'b0010;
  localparam logic [3:0] B_L = 4'b0100;
  localparam logic [3:0] B_R = 4'b1000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       btnU, btnD, btnL, btnR;
  logic       cmd_valid;
  logic [3:0] cmd_dir;
  logic       cmd_ready;
  logic [3:0] btn;

  int total = 0;
  int bad   = 0;

  assign {btnR, btnL, btnD, btnU} = btn;

  always #5 Clk = ~Clk;

  move_cmd_gen #(.DEBOUNCE_CYCLES(D)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .btnU      (btnU),
    .btnD      (btnD),
    .btnL      (btnL),
    .btnR      (btnR),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready)
  );

  // Reference model: run lengths of synchronized samples rather than states.
  bit         m_pending, m_armed;
  int         m_run, m_zeros;
  logic [3:0] m_pat, m_dir;
  logic [3:0] m_hist [2];

  int         obs_xfer = 0;
  int         seen_valid = 0;
  logic [3:0] last_dir = 4'b0000;

  function automatic logic [3:0] lowest_bit(input logic [3:0] p);
    for (int i = 0; i < 4; i++)
      if (p[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_model(input logic rst, input logic [3:0] raw, input logic rdy);
    logic [3:0] s;
    if (rst) begin
      m_pending = 0; m_armed = 0; m_run = 0; m_zeros = 0;
      m_pat = 0; m_dir = 0; m_hist[0] = 0; m_hist[1] = 0;
      return;
    end
    s = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = raw;
    if (m_pending) begin
      if (rdy) begin
        m_pending = 0;
        m_zeros   = 0;
      end
    end else if (!m_armed) begin
      m_zeros = (s == 4'b0000) ? m_zeros + 1 : 0;
      if (m_zeros == D) begin
        m_armed = 1;
        m_run   = 0;
      end
    end else begin
      if (s == 4'b0000) m_run = 0;
      else if (m_run > 0 && s == m_pat) m_run++;
      else begin
        m_run = 1;
        m_pat = s;
      end
      if (m_run == D + 1) begin
        m_pending = 1;
        m_armed   = 0;
        m_dir     = lowest_bit(m_pat);
      end
    end
  endtask

  task automatic tick(input logic [3:0] b, input logic rdy);
    btn = b;
    cmd_ready = rdy;
    #1;
    if (!Reset && cmd_valid && rdy) obs_xfer++;
    @(posedge Clk);
    step_model(Reset, b, rdy);
    #1;
    check("model", {27'd0, cmd_valid, cmd_dir}, {27'd0, m_pending, m_pending ? m_dir : 4'b0000});
    if (cmd_valid) begin
      seen_valid++;
      last_dir = cmd_dir;
    end
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b0000, 1'b0);
  endtask

  task automatic wait_valid(input logic [3:0] b, input int limit);
    int n;
    n = 0;
    while (!cmd_valid && n < limit) begin
      tick(b, 1'b0);
      n++;
    end
    check("wait_valid", {31'd0, cmd_valid}, 32'd1);
  endtask

  typedef struct {
    logic [3:0] b;
    logic       rdy;
    logic       v;
    logic [3:0] d;
  } vec_t;

  vec_t tv [$];

  initial begin
    int x0, s0;
    logic [3:0] rb;
    logic [3:0] s3 [13];

    // Scenario 1: btnL held, ready high; one-cycle command after edge k+6.
    for (int i = 0; i < 12; i++)
      tv.push_back('{B_L, 1'b1, (i == 6), (i == 6) ? B_L : 4'b0000});
    for (int i = 0; i < 6; i++)
      tv.push_back('{4'b0000, 1'b1, 1'b0, 4'b0000});
    // Scenario 3: btnD bounces before settling; command after the 4th stable sample.
    s3 = '{B_D, 0, B_D, B_D, 0, B_D, B_D, B_D, B_D, B_D, B_D, B_D, B_D};
    for (int i = 0; i < 13; i++)
      tv.push_back('{s3[i], 1'b1, (i == 11), (i == 11) ? B_D : 4'b0000});

    btn = 0; cmd_ready = 0; Reset = 1;
    for (int i = 0; i < 3; i++) tick(4'b0000, 1'b0);
    Reset = 0;
    check("reset_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_dir", {28'd0, cmd_dir}, 32'd0);
    idle(8);

    for (int i = 0; i < tv.size(); i++) begin
      tick(tv[i].b, tv[i].rdy);
      check("vec", {27'd0, cmd_valid, cmd_dir}, {27'd0, tv[i].v, tv[i].d});
    end
    idle(8);

    // Scenario 2: up+right together -> exactly one up command.
    x0 = obs_xfer; s0 = seen_valid;
    for (int i = 0; i < 15; i++) tick(B_U | B_R, 1'b1);
    check("s2_xfers", obs_xfer - x0, 1);
    check("s2_valid_cycles", seen_valid - s0, 1);
    check("s2_dir", {28'd0, last_dir}, {28'd0, B_U});
    idle(8);

    // Scenario 4: command held through release while ready is low.
    wait_valid(B_R, 20);
    x0 = obs_xfer;
    for (int i = 0; i < 20; i++) begin
      tick(4'b0000, 1'b0);
      check("s4_hold", {27'd0, cmd_valid, cmd_dir}, {27'd0, 1'b1, B_R});
    end
    tick(4'b0000, 1'b1);
    check("s4_xfer", obs_xfer - x0, 1);
    check("s4_drop", {31'd0, cmd_valid}, 32'd0);
    idle(8);

    // Scenario 5: button held across reset never issues until released and pressed again.
    s0 = seen_valid;
    Reset = 1;
    for (int i = 0; i < 3; i++) tick(B_U, 1'b1);
    Reset = 0;
    for (int i = 0; i < 50; i++) tick(B_U, 1'b1);
    check("s5_none", seen_valid - s0, 0);
    idle(8);
    x0 = obs_xfer;
    for (int i = 0; i < 12; i++) tick(B_U, 1'b1);
    check("s5_xfer", obs_xfer - x0, 1);
    check("s5_dir", {28'd0, last_dir}, {28'd0, B_U});
    idle(8);

    // Scenario 6: reset during a pending command drops it.
    wait_valid(B_L, 20);
    x0 = obs_xfer;
    Reset = 1;
    tick(B_L, 1'b0);
    check("s6_valid", {31'd0, cmd_valid}, 32'd0);
    check("s6_dir", {28'd0, cmd_dir}, 32'd0);
    Reset = 0;
    idle(10);
    check("s6_noxfer", obs_xfer - x0, 0);

    // Randomized run against the model.
    rb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0)
        rb = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      Reset = ($urandom_range(0, 499) == 0);
      tick(rb, ($urandom_range(0, 2) != 0));
    end
    Reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_cmd_gen.md
MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 Parameters: DEBOUNCE_CYCLES, default 500000, number of consecutive stable cycles (at least 1) that qualify a press or a release.
REQ-002 Clock: one clock only; reset is synchronous and active-high.
REQ-003 Port: Clk  input  1  system clock; every register updates on its rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Ports: btnU, btnD, btnL, btnR  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 Port: cmd_valid  output  1  a move command is pending.
REQ-007 Port: cmd_dir  output  4  one-hot direction: 0001 up, 0010 down, 0100 left, 1000 right.
REQ-008 Port: cmd_ready  input  1  the game core accepts the command this cycle.

Function
REQ-009 Each button passes through a two-flop synchronizer; the state machine sees only synchronized values.
REQ-010 The state machine has four states: IDLE, DEBOUNCE, ISSUE and WAIT_RELEASE.
REQ-011 IDLE: if the synchronized pattern is nonzero, latch the pattern, clear the counter and go to DEBOUNCE; otherwise stay in IDLE.
REQ-012 DEBOUNCE, pattern now zero: go to IDLE.
REQ-013 DEBOUNCE, pattern nonzero but different from the latched value: latch the new pattern, clear the counter and stay in DEBOUNCE.
REQ-014 DEBOUNCE, pattern equal to the latched value and counter = DEBOUNCE_CYCLES-1: go to ISSUE; otherwise increment the counter.
REQ-015 On entry to ISSUE, cmd_dir is the priority encoding of the latched pattern: up > down > left > right, always exactly one bit set.
REQ-016 cmd_valid = 1 only in ISSUE; cmd_dir = 0000 whenever cmd_valid = 0.
REQ-017 cmd_dir stays constant while cmd_valid = 1.
REQ-018 In ISSUE, cmd_valid holds until cmd_ready = 1 is sampled; a transfer occurs on that edge and the next state is WAIT_RELEASE.
REQ-019 cmd_ready while cmd_valid = 0 is ignored.
REQ-020 Releasing the buttons during ISSUE does not withdraw the command.
REQ-021 WAIT_RELEASE: after DEBOUNCE_CYCLES consecutive cycles with the synchronized pattern all-zero, go to IDLE.
REQ-022 WAIT_RELEASE: any nonzero sample clears the counter; a held button yields exactly one command.
REQ-023 Latency: if a pattern is first sampled at edge k and stays stable, cmd_valid rises after edge k+2+DEBOUNCE_CYCLES.
REQ-024 The debounce counter is ceil(log2(DEBOUNCE_CYCLES+1)) bits wide and never wraps, because it is cleared on every transition.
REQ-025 Simultaneous press and cmd_ready: no effect outside ISSUE; no command is queued, and at most one command is outstanding.

Reset
REQ-026 Reset clears the synchronizers, counter, latched pattern, cmd_valid (0) and cmd_dir (0000).
REQ-027 Reset forces the state to WAIT_RELEASE, so buttons held across reset never produce a command.
REQ-028 Reset asserted mid-ISSUE drops the pending command with no transfer.

Structure
REQ-029 Package game2048_pkg holds the DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT one-hot constants, which the game core also uses.
REQ-030 Package game2048_pkg also holds the move_cmd_gen state encoding.
REQ-031 One sub-module, btn_sync, is a 4-bit two-flop synchronizer instantiated once.

Verification (DEBOUNCE_CYCLES = 4)
REQ-032 Scenario 1: reset released, then btnL held with cmd_ready = 1 -> cmd_valid high for exactly one cycle, 6 edges after first sample, with cmd_dir = 0100.
REQ-033 Scenario 2: btnU and btnR pressed together and held -> one command, cmd_dir = 0001.
REQ-034 Scenario 3: btnD bounces (1,0,1,1,0,1,1,1,1 ...) -> no command until 4 stable samples; then exactly one command, 0010.
REQ-035 Scenario 4: cmd_ready held 0 for 20 cycles while btnR is released -> cmd_valid and cmd_dir = 1000 held throughout; transfer when cmd_ready rises.
REQ-036 Scenario 5: btnU held through reset and 50 cycles beyond -> no command; release 4+ cycles, press again -> one command, 0001.
REQ-037 Scenario 6: Reset pulsed while cmd_valid = 1 -> next cycle cmd_valid = 0 and cmd_dir = 0000, with no transfer counted.
